// File: rtl/deconv_pkg.sv
// deconv_pkg: shared sizes, FSM state encoding and small widening helpers
// for the sequential deconvolution block (deconv_seq) and its divider.
//   N    samples per input signal
//   DW   bits per a/b sample (unsigned)
//   YW   bits per y sample (unsigned)
//   ACCW signed accumulator width; two bits above YW so that y minus any
//        partial sum of products can never wrap
//   NY   samples in the convolution product y (2N-1)
package deconv_pkg;

    localparam int N    = 16;
    localparam int DW   = 8;
    localparam int YW   = 20;
    localparam int ACCW = YW + 2;
    localparam int NY   = 2 * N - 1;
    localparam int KW   = $clog2(N);
    localparam int MW   = $clog2(NY);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        LOAD,
        MAC,
        DIV,
        RLOAD,
        RMAC,
        RCMP,
        DONE
    } state_t;

    // Zero-extend an unsigned y sample into the signed accumulator domain.
    function automatic logic signed [ACCW-1:0] y_to_acc(input logic [YW-1:0] v);
        return $signed({{(ACCW-YW){1'b0}}, v});
    endfunction

    // Zero-extend an unsigned DW x DW product into the accumulator domain.
    function automatic logic signed [ACCW-1:0] prod_to_acc(input logic [2*DW-1:0] v);
        return $signed({{(ACCW-2*DW){1'b0}}, v});
    endfunction

endpackage

// File: rtl/deconv_seq_if.sv
// deconv_seq_if: request/result bundle of the deconvolution block.
//   start              requester -> block, accepted only while busy is low
//   signal_y           convolution product, index 0 first
//   signal_a           known factor
//   busy               high from the accept edge until done
//   done               one-cycle pulse when the results are valid
//   signal_b           recovered factor, held until the next accept
//   invalid_input_flag a[0]==0 or a quotient was not a valid DW-bit integer
//   inexact_flag       tail samples of y disagree with a (*) b
// Modports: master drives the request (testbench / upstream), slave is the block.
interface deconv_seq_if;
    import deconv_pkg::*;

    logic                     start;
    logic [NY-1:0][YW-1:0]    signal_y;
    logic [N-1:0][DW-1:0]     signal_a;
    logic                     busy;
    logic                     done;
    logic [N-1:0][DW-1:0]     signal_b;
    logic                     invalid_input_flag;
    logic                     inexact_flag;

    modport master (
        output start, signal_y, signal_a,
        input  busy, done, signal_b, invalid_input_flag, inexact_flag
    );

    modport slave (
        input  start, signal_y, signal_a,
        output busy, done, signal_b, invalid_input_flag, inexact_flag
    );

endinterface

// File: rtl/deconv_div.sv
// deconv_div: DW-bit restoring divider, one quotient bit per clock.
//   clk, rst  clock and synchronous active-high reset
//   go        start a division (operands sampled on this edge)
//   num       non-negative dividend, must be below den << DW
//   den       divisor, non-zero
//   busy      division in progress
//   valid     one-cycle pulse, DW cycles after go, quo/rem_nz valid
//   quo       quotient
//   rem_nz    remainder is non-zero
// The first quotient bit is resolved on the go edge itself, so the result
// is registered after exactly DW edges.
module deconv_div
    import deconv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [ACCW-1:0] num,
    input  logic [DW-1:0]   den,
    output logic            busy,
    output logic            valid,
    output logic [DW-1:0]   quo,
    output logic            rem_nz
);

    localparam int CW = $clog2(DW);

    logic [ACCW-1:0] rem_q, rem_d;
    logic [ACCW-1:0] dsh_q, dsh_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;

    logic            step;
    logic            take;
    logic [ACCW-1:0] src_r;
    logic [ACCW-1:0] src_s;

    always_comb begin
        step    = go || (cnt_q != '0);
        src_r   = go ? num : rem_q;
        // Divisor aligned to the quotient MSB; shifted right one place per step.
        src_s   = go ? (ACCW'(den) << (DW - 1)) : dsh_q;
        take    = (src_r >= src_s);
        rem_d   = take ? (src_r - src_s) : src_r;
        dsh_d   = src_s >> 1;
        quo_d   = go ? {{(DW-1){1'b0}}, take} : {quo_q[DW-2:0], take};
        cnt_d   = go ? CW'(DW - 1) : (cnt_q - CW'(1));
        valid_d = !go && (cnt_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            dsh_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (step) begin
                rem_q <= rem_d;
                dsh_q <= dsh_d;
                quo_q <= quo_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign busy   = (cnt_q != '0);
    assign valid  = valid_q;
    assign quo    = quo_q;
    assign rem_nz = (rem_q != '0);

endmodule

// File: rtl/deconv_seq.sv
// deconv_seq: sequential deconvolution by polynomial long division.
// Recovers b from y = a (*) b and a, one shared multiplier and one divider.
//   clk, rst  clock and synchronous active-high reset
//   bus       deconv_seq_if.slave: start/signal_y/signal_a in,
//             busy/done/signal_b/invalid_input_flag/inexact_flag out
// Forward phase, sample k: acc = y[k] - sum a[j]*b[k-j] (j=1..k), then
// b[k] = acc / a[0]. Residual phase, m = N..NY-1: y[m] must equal the
// remaining convolution terms, otherwise the inexact flag is raised.
// The CHECK cycle also loads y[0], standing in for the first LOAD, so the
// extra DONE cycle keeps the done pulse 431 cycles after accept on a clean
// run and 2 cycles after accept when a[0] is zero.
module deconv_seq
    import deconv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    deconv_seq_if.slave  bus
);

    state_t state_q, state_d;

    logic [YW-1:0] y_q [NY];
    logic [DW-1:0] a_q [N];
    logic [DW-1:0] b_q [N];

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [KW-1:0]          k_q, k_d;
    logic [KW-1:0]          j_q, j_d;
    logic [MW-1:0]          m_q, m_d;
    logic                   div_wait_q, div_wait_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   invalid_q, invalid_d;
    logic                   inexact_q, inexact_d;

    logic                   accept;
    logic                   b_we;
    logic                   div_go;
    logic                   div_busy;
    logic                   div_valid;
    logic [DW-1:0]          div_quo;
    logic                   div_rem_nz;

    logic [KW-1:0]          bidx;
    logic [2*DW-1:0]        prod;
    logic signed [ACCW-1:0] prod_acc;
    logic signed [ACCW-1:0] div_limit;

    // Shared MAC operand select: b index is k-j forward, m-j in the residual.
    assign bidx      = (state_q == RMAC) ? KW'(m_q - MW'(j_q)) : (k_q - j_q);
    assign prod      = a_q[j_q] * b_q[bidx];
    assign prod_acc  = prod_to_acc(prod);
    // Any accumulator at or above a[0] << DW would need a quotient wider than DW.
    assign div_limit = $signed({{(ACCW-2*DW){1'b0}}, a_q[0], {DW{1'b0}}});

    assign accept    = (state_q == IDLE) && bus.start;

    deconv_div u_div (
        .clk    (clk),
        .rst    (rst),
        .go     (div_go),
        .num    ($unsigned(acc_q)),
        .den    (a_q[0]),
        .busy   (div_busy),
        .valid  (div_valid),
        .quo    (div_quo),
        .rem_nz (div_rem_nz)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        k_d        = k_q;
        j_d        = j_q;
        m_d        = m_q;
        div_wait_d = div_wait_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        invalid_d  = invalid_q;
        inexact_d  = inexact_q;
        div_go     = 1'b0;
        b_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CHECK;
                    busy_d    = 1'b1;
                    invalid_d = 1'b0;
                    inexact_d = 1'b0;
                end
            end

            CHECK: begin
                if (a_q[0] == '0) begin
                    invalid_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    // Sample 0 has no MAC terms: load y[0] and divide directly.
                    acc_d      = y_to_acc(y_q[0]);
                    k_d        = '0;
                    div_wait_d = 1'b0;
                    state_d    = DIV;
                end
            end

            LOAD: begin
                acc_d      = y_to_acc(y_q[{1'b0, k_q}]);
                j_d        = KW'(1);
                div_wait_d = 1'b0;
                state_d    = (k_q == '0) ? DIV : MAC;
            end

            MAC: begin
                acc_d = acc_q - prod_acc;
                if (j_q == k_q) begin
                    div_wait_d = 1'b0;
                    state_d    = DIV;
                end else begin
                    j_d = j_q + KW'(1);
                end
            end

            DIV: begin
                if (!div_wait_q) begin
                    // Range check cycle; the divider is launched only if it passes.
                    if (acc_q[ACCW-1] || (acc_q >= div_limit)) begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else if (!div_busy) begin
                        div_go     = 1'b1;
                        div_wait_d = 1'b1;
                    end
                end else if (div_valid) begin
                    div_wait_d = 1'b0;
                    if (div_rem_nz) begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        b_we = 1'b1;
                        if (k_q == KW'(N - 1)) begin
                            m_d     = MW'(N);
                            state_d = RLOAD;
                        end else begin
                            k_d     = k_q + KW'(1);
                            state_d = LOAD;
                        end
                    end
                end
            end

            RLOAD: begin
                acc_d   = y_to_acc(y_q[m_q]);
                j_d     = KW'(m_q - MW'(N - 1));
                state_d = RMAC;
            end

            RMAC: begin
                acc_d = acc_q - prod_acc;
                if (j_q == KW'(N - 1)) begin
                    state_d = RCMP;
                end else begin
                    j_d = j_q + KW'(1);
                end
            end

            RCMP: begin
                if (acc_q != '0) begin
                    inexact_d = 1'b1;
                end
                if (m_q == MW'(NY - 1)) begin
                    state_d = DONE;
                end else begin
                    m_d     = m_q + MW'(1);
                    state_d = RLOAD;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            j_q        <= '0;
            m_q        <= '0;
            div_wait_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            j_q        <= j_d;
            m_q        <= m_d;
            div_wait_q <= div_wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            invalid_q  <= invalid_d;
            inexact_q  <= inexact_d;
        end
    end

    // Input snapshot; the requester may change its inputs after accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NY; i++) begin
                y_q[i] <= bus.signal_y[i];
            end
            for (int i = 0; i < N; i++) begin
                a_q[i] <= bus.signal_a[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            for (int i = 0; i < N; i++) begin
                b_q[i] <= '0;
            end
        end else if (b_we) begin
            b_q[k_q] <= div_quo;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_b_out
            assign bus.signal_b[gi] = b_q[gi];
        end
    endgenerate

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.invalid_input_flag = invalid_q;
    assign bus.inexact_flag       = inexact_q;

endmodule

// File: tb/tb_deconv_seq.sv
// tb_deconv_seq: directed plus randomized bench for deconv_seq. Expected
// results come from a plain-integer long-division model of the block.
module tb_deconv_seq;
    import deconv_pkg::*;

    typedef logic [NY-1:0][YW-1:0] yv_t;
    typedef logic [N-1:0][DW-1:0]  av_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    deconv_seq_if bus();

    deconv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic yv_t conv(input av_t a, input av_t b);
        yv_t y;
        int  s;
        for (int n = 0; n < NY; n++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (n - i >= 0 && n - i < N) s += int'(a[i]) * int'(b[n - i]);
            end
            y[n] = YW'(s);
        end
        return y;
    endfunction

    // Long division of y by a, then tail comparison.
    function automatic void ref_model(input yv_t y, input av_t a,
                                      output av_t b, output bit inv, output bit inex);
        int acc;
        int q;
        b    = '0;
        inv  = 1'b0;
        inex = 1'b0;
        if (a[0] == '0) begin
            inv = 1'b1;
            return;
        end
        for (int k = 0; k < N; k++) begin
            acc = int'(y[k]);
            for (int j = 1; j <= k; j++) acc -= int'(a[j]) * int'(b[k - j]);
            if (acc < 0 || (acc % int'(a[0])) != 0) begin
                inv = 1'b1;
                return;
            end
            q = acc / int'(a[0]);
            if (q > 255) begin
                inv = 1'b1;
                return;
            end
            b[k] = DW'(q);
        end
        for (int m = N; m < NY; m++) begin
            acc = int'(y[m]);
            for (int j = m - (N - 1); j < N; j++) acc -= int'(a[j]) * int'(b[m - j]);
            if (acc != 0) inex = 1'b1;
        end
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < NY; i++) bus.signal_y[i] = YW'($urandom);
        for (int i = 0; i < N; i++)  bus.signal_a[i] = DW'($urandom);
    endtask

    // One full request; inject_at > 0 pulses a (to be ignored) start mid-run.
    task automatic run_case(input string tag, input yv_t y, input av_t a, input int inject_at);
        av_t eb;
        bit  einv;
        bit  einx;
        int  lat;
        bit  seen;
        ref_model(y, a, eb, einv, einx);
        @(negedge clk);
        bus.signal_y = y;
        bus.signal_a = a;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
        check({tag, "_busy_on_accept"}, bus.busy, 1'b1);
        check({tag, "_flags_cleared"}, {bus.invalid_input_flag, bus.inexact_flag}, 2'b00);
        check({tag, "_b_cleared"}, bus.signal_b, '0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.start) bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
            end else if (lat == inject_at) begin
                scramble_inputs();
                bus.start = 1'b1;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        if (!einv)            check({tag, "_latency"}, lat, 431);
        else if (a[0] == '0)  check({tag, "_latency"}, lat, 2);
        else                  check({tag, "_early_done"}, lat < 431, 1'b1);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check({tag, "_signal_b"}, bus.signal_b, eb);
        check({tag, "_invalid"}, bus.invalid_input_flag, einv);
        check({tag, "_inexact"}, bus.inexact_flag, einx);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
        check({tag, "_b_held"}, bus.signal_b, eb);
        $display("txn %s: lat=%0d invalid=%0b inexact=%0b b=%h", tag, lat,
                 bus.invalid_input_flag, bus.inexact_flag, bus.signal_b);
    endtask

    initial begin
        av_t a1, b1, a2, b2, a3, a4, ar, br;
        yv_t y1, y2, y3, y4, y5, yr;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.start    = 1'b0;
        bus.signal_y = '0;
        bus.signal_a = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_b", bus.signal_b, '0);
        check("reset_flags", {bus.invalid_input_flag, bus.inexact_flag}, 2'b00);
        rst = 1'b0;

        // 1: a = {1,1,0..}, b = 1..16
        a1 = '0; a1[0] = 8'd1; a1[1] = 8'd1;
        for (int i = 0; i < N; i++) b1[i] = DW'(i + 1);
        y1 = conv(a1, b1);
        run_case("t1_basic", y1, a1, 0);
        check("t1_b_is_1_to_16", bus.signal_b, b1);

        // 2: all-255 operands, largest y values
        a2 = '1; b2 = '1;
        y2 = conv(a2, b2);
        run_case("t2_max", y2, a2, 0);
        check("t2_b_all_255", bus.signal_b, b2);

        // 3: a[0] == 0
        a3 = '0;
        for (int i = 1; i < N; i++) a3[i] = 8'd1;
        run_case("t3_a0_zero", y1, a3, 0);

        // 4: non-integer first quotient
        a4 = '0; a4[0] = 8'd2;
        y3 = '0; y3[0] = 20'd7;
        run_case("t4_remainder", y3, a4, 0);

        // 5: tail mismatch only
        y4 = y1; y4[NY-1] = y4[NY-1] + 20'd1;
        run_case("t5_inexact", y4, a1, 0);

        // 6a: start while busy is ignored
        run_case("t6_ignored_start", y1, a1, 100);

        // 6b: reset mid-operation discards the partial result
        @(negedge clk);
        bus.signal_y = y1;
        bus.signal_a = a1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        check("t6_busy_before_rst", bus.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_done", bus.done, 1'b0);
        check("t6_rst_flags", {bus.invalid_input_flag, bus.inexact_flag}, 2'b00);
        check("t6_rst_b", bus.signal_b, '0);
        $display("txn t6_reset: busy=%0b b=%h", bus.busy, bus.signal_b);
        run_case("t6_after_rst", y1, a1, 0);

        // Randomized: clean, tail-perturbed and head-perturbed products
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                ar[i] = DW'($urandom_range(0, 255));
                br[i] = DW'($urandom_range(0, 255));
            end
            ar[0] = DW'($urandom_range(1, 255));
            yr = conv(ar, br);
            if (r % 3 == 1) begin
                y5 = yr;
                y5[N + $urandom_range(0, N - 2)] += YW'($urandom_range(1, 100));
                yr = y5;
            end else if (r % 3 == 2) begin
                y5 = yr;
                y5[$urandom_range(0, N - 1)] += YW'(1);
                yr = y5;
            end
            run_case($sformatf("rand%0d", r), yr, ar, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
